// File: rtl/piso_serial_ctrl_pkg.sv
// Shared definitions for the parallel-in/serial-out sequencer:
// FSM state encodings and bit-order selectors.
package piso_serial_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  localparam bit BIT_ORDER_MSB = 1'b0;
  localparam bit BIT_ORDER_LSB = 1'b1;

endpackage

// File: rtl/piso_serial_ctrl_if.sv
// Word-in / bit-out bus of the serial sequencer.
// The producer/consumer side uses master, the sequencer uses slave.
interface piso_serial_ctrl_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              frame_start;
  logic              frame_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, ser_valid, frame_start, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, ser_valid, frame_start, frame_done
  );
endinterface

// File: rtl/piso_serial_ctrl_shift.sv
// DATA_W-bit shift register with clear/load/shift controls.
// bit_o always presents the bit that leaves first in the chosen order.
module piso_serial_ctrl_shift
  import piso_serial_ctrl_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter bit LSB_FIRST = BIT_ORDER_LSB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              bit_o
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  // Clear beats load beats shift; vacated positions fill with zero.
  always_comb begin
    sr_d = sr_q;
    if (clear_i) begin
      sr_d = '0;
    end else if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      if (LSB_FIRST == BIT_ORDER_LSB) begin
        sr_d = {1'b0, sr_q[DATA_W-1:1]};
      end else begin
        sr_d = {sr_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = (LSB_FIRST == BIT_ORDER_LSB) ? sr_q[0] : sr_q[DATA_W-1];

endmodule

// File: rtl/piso_serial_ctrl.sv
// Load/shift/gap sequencer: accepts a word, emits DATA_W bits one per clock,
// then idles GAP_CYC cycles plus one IDLE cycle before the next accept.
module piso_serial_ctrl
  import piso_serial_ctrl_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int GAP_CYC   = 1,
  parameter bit LSB_FIRST = BIT_ORDER_LSB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  output logic                busy_o,
  piso_serial_ctrl_if.slave   bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [3:0] GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             start_q, start_d;
  logic             done_q, done_d;

  logic inReady;
  logic accept;
  logic shiftEn;
  logic coreBit;

  assign inReady = (state_q == ST_IDLE) && !flush_i;
  assign accept  = bus.in_valid && inReady;

  piso_serial_ctrl_shift #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush_i),
    .load_i  (accept),
    .shift_i (shiftEn),
    .data_i  (bus.in_data),
    .bit_o   (coreBit)
  );

  // Frame flags default low so they drop on the first edge outside SHIFT;
  // flush overrides every state and blocks the accept in the same cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = 1'b0;
    start_d     = 1'b0;
    done_d      = 1'b0;
    shiftEn     = 1'b0;
    if (flush_i) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
          end
        end
        ST_SHIFT: begin
          shiftEn     = 1'b1;
          ser_out_d   = coreBit;
          ser_valid_d = 1'b1;
          start_d     = (bit_cnt_q == '0);
          done_d      = (bit_cnt_q == BIT_LAST);
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      start_q     <= start_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = start_q;
  assign bus.frame_done  = done_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule
